// File: rtl/wave_capture_pkg.sv
// rtl/wave_capture_pkg.sv - shared state encoding, defaults and sample conversion for wave_capture
package wave_capture_pkg;

   localparam int DEFAULT_SAMPLES  = 256;
   localparam int DEFAULT_DECIMATE = 1;

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   // Signed PCM high byte to offset-binary display byte (midscale = 0x80).
   function automatic logic [7:0] to_offset8(input logic [7:0] hi_byte);
      return {~hi_byte[7], hi_byte[6:0]};
   endfunction

endpackage

// File: rtl/zero_crossing_detector.sv
// rtl/zero_crossing_detector.sv - flags a negative-to-non-negative step between consecutive accepted samples
module zero_crossing_detector (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic sample_valid,
   input  logic sample_sign,
   output logic trigger
);

   logic prev_sign;
   logic prev_valid;

   // Only the sign of the previous sample matters for the crossing test.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_sign  <= 1'b0;
         prev_valid <= 1'b0;
      end else if (clear) begin
         prev_sign  <= 1'b0;
         prev_valid <= 1'b0;
      end else if (sample_valid) begin
         prev_sign  <= sample_sign;
         prev_valid <= 1'b1;
      end
   end

   assign trigger = sample_valid & prev_valid & prev_sign & ~sample_sign;

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - triggered, decimated audio capture into a double-buffered display RAM
module wave_capture
   import wave_capture_pkg::*;
#(
   parameter int SAMPLES  = DEFAULT_SAMPLES,
   parameter int DECIMATE = DEFAULT_DECIMATE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_sample_ready,
   input  logic [15:0] new_sample_in,
   input  logic        display_idle,
   output logic        write_enable,
   output logic [8:0]  write_address,
   output logic [7:0]  write_sample,
   output logic        read_index,
   output logic        capture_done
);

   localparam logic [7:0] LAST_INDEX = 8'(SAMPLES - 1);
   localparam logic [3:0] DEC_LAST   = 4'(DECIMATE - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] dec_cnt;
   logic [7:0] index;
   logic [7:0] wr_index;
   logic       accept;
   logic       trigger;
   logic       write_now;
   logic       done_now;
   logic       swap_now;
   logic       unused_low_bits;

   // The display only resolves the top byte of each sample.
   assign unused_low_bits = ^new_sample_in[7:0];

   assign accept   = new_sample_ready && (state != ST_WAIT) && (dec_cnt == 4'd0);
   assign wr_index = (state == ST_ARMED) ? 8'd0 : index;

   zero_crossing_detector u_zero_crossing (
      .clk          (clk),
      .reset        (reset),
      .clear        (state != ST_ARMED),
      .sample_valid (accept && (state == ST_ARMED)),
      .sample_sign  (new_sample_in[15]),
      .trigger      (trigger)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_ARMED;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_ARMED:  if (trigger) state_next = ST_ACTIVE;
         ST_ACTIVE: if (accept && (index == LAST_INDEX)) state_next = ST_WAIT;
         ST_WAIT:   if (display_idle) state_next = ST_ARMED;
         default:   state_next = ST_ARMED;
      endcase
   end

   always_comb begin
      write_now = 1'b0;
      done_now  = 1'b0;
      swap_now  = 1'b0;
      case (state)
         ST_ARMED:  write_now = trigger;
         ST_ACTIVE: begin
            write_now = accept;
            done_now  = accept && (index == LAST_INDEX);
         end
         ST_WAIT:   swap_now = display_idle;
         default:   ;
      endcase
   end

   // Decimation phase restarts from zero for every new arm.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_cnt <= 4'd0;
      end else if (state == ST_WAIT) begin
         dec_cnt <= 4'd0;
      end else if (new_sample_ready) begin
         dec_cnt <= (dec_cnt == DEC_LAST) ? 4'd0 : dec_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         index <= 8'd0;
      end else if ((state == ST_ARMED) && trigger) begin
         index <= 8'd1;
      end else if ((state == ST_ACTIVE) && accept) begin
         index <= (index == LAST_INDEX) ? 8'd0 : index + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_index <= 1'b0;
      end else if (swap_now) begin
         read_index <= ~read_index;
      end
   end

   // Capture always targets the bank the display is not reading.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_enable  <= 1'b0;
         capture_done  <= 1'b0;
         write_address <= 9'd0;
         write_sample  <= 8'd0;
      end else begin
         write_enable <= write_now;
         capture_done <= done_now;
         if (write_now) begin
            write_address <= {~read_index, wr_index};
            write_sample  <= to_offset8(new_sample_in[15:8]);
         end
      end
   end

endmodule
